video_timer_ctrl: RTL and testbench
===================================

VIDEO_TIMER_CTRL -- requirements
Module: video_timer_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning the number of cycles reset_timer is held after a mode load (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock (27 MHz); all flops use its rising edge.
REQ-003 SHALL have port reset_b, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port enable, input, 1 bit: 1 runs the timer, 0 parks it.
REQ-005 SHALL have port mode_req_valid, input, 1 bit: a mode-change request is present.
REQ-006 SHALL have port mode_req, input, 2 bits: the requested mode (0=NTSC, 1=PAL, 2=VGA, 3=reserved).
REQ-007 SHALL have port mode_req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-008 SHALL have ports pix_counter (12 bits) and line_counter (10 bits), both inputs, fed back from the timer.
REQ-009 SHALL have timer configuration outputs, all registered: ticks_per_line, hs_pix_start, hs_pix_stop, vs_pix_start and vs_pix_stop (12 bits each); lines_per_frame, vs_line_start, vs_line_stop and starting_line (10 bits each); active_high_syncs (1 bit).
REQ-010 SHALL have port reset_timer, output, 1 bit: synchronous clear to the timer.
REQ-011 SHALL have port mode_active, output, 2 bits: the mode currently loaded.
REQ-012 SHALL have ports running, frame_start and mode_err, outputs, 1 bit each: run status, a start-of-frame pulse and a bad-request pulse.

Function
REQ-013 SHALL implement a state machine with states IDLE, HOLD, RUN and PEND.
REQ-014 SHALL drive mode_req_ready=1 in IDLE and in RUN, and 0 in HOLD and in PEND.
REQ-015 SHALL accept a request only on a cycle where mode_req_valid and mode_req_ready are both 1.
REQ-016 SHALL, when a request with mode 3 is accepted, pulse mode_err for 1 cycle, ignore the request and leave the state unchanged.
REQ-017 SHALL, when a valid request is accepted in IDLE, load the mode table entry on the next edge and update mode_active, staying in IDLE.
REQ-018 SHALL, when a valid request is accepted in RUN, latch the mode into a pending register and go to PEND.
REQ-019 SHALL, in PEND, detect end of frame (pix_counter==ticks_per_line and line_counter==lines_per_frame), then on the next edge load the pending mode and go to HOLD.
REQ-020 SHALL, in IDLE with enable=1, go to HOLD.
REQ-021 SHALL, in HOLD, assert reset_timer for exactly SETTLE_CYCLES cycles using a 4-bit counter, then go to RUN.
REQ-022 SHALL drive reset_timer=1 in IDLE and HOLD and 0 in RUN and PEND.
REQ-023 SHALL drive running=1 only in RUN and PEND.
REQ-024 SHALL, when enable=0 in any state, go to IDLE on the next edge and discard any pending request; enable=0 has priority over end of frame.
REQ-025 SHALL pulse frame_start for 1 cycle in RUN or PEND when pix_counter==0 and line_counter==0.
REQ-026 SHALL change the configuration outputs only on a load edge, never while reset_timer=0.

Reset
REQ-027 SHALL, while reset_b=0, set state=IDLE, mode_active=0, the NTSC table entry on all configuration outputs, reset_timer=1, running=0, frame_start=0, mode_err=0, the settle counter to 0 and pending cleared.
REQ-028 SHALL drive mode_req_ready=1 in the first cycle after reset release.

Configuration
REQ-029 SHALL, with VIDEO_TIMER_CTRL_FRAME_COUNT_EN defined, add an output frame_count (16 bits) that increments on each frame_start, wraps 0xFFFF to 0 and clears on reset and on every load.
REQ-030 SHALL, without VIDEO_TIMER_CTRL_FRAME_COUNT_EN, have neither the frame_count port nor its logic.

Structure
REQ-031 SHALL place the mode encoding constants and the per-mode timing table in the shared package video_timer_pkg; NTSC ticks/lines=1715/524, PAL=1727/624, VGA=799/524.
REQ-032 SHALL use one sub-module, video_mode_rom: a combinational mode-to-timing lookup instantiated once.

Verification
REQ-033 SHALL test reset: with enable=0, reset_timer=1, ticks_per_line=1715, lines_per_frame=524 and mode_req_ready=1.
REQ-034 SHALL test start-up: enable=1 from IDLE gives reset_timer high for exactly 4 cycles, then running=1.
REQ-035 SHALL test a mid-frame request: mode_req=1 in RUN gives PEND with ready=0; at pix_counter=1715 and line_counter=524 the next edge sets ticks_per_line=1727 and mode_active=1, then reset_timer is held 4 cycles.
REQ-036 SHALL test a bad request: mode_req=3 accepted gives a 1-cycle mode_err pulse with no state or output change.
REQ-037 SHALL test an enable drop in PEND: the next edge is IDLE with reset_timer=1, and mode_active is still the old mode.
REQ-038 SHALL test the frame counter with the macro defined: 3 frames give frame_count=3, and a mode load clears it to 0.

Source files
------------

// File: rtl/video_timer_pkg.sv
// Shared mode encodings, controller states and the per-mode timing table for video_timer_ctrl.
package video_timer_pkg;

   typedef enum logic [1:0] {
      MODE_NTSC = 2'd0,
      MODE_PAL  = 2'd1,
      MODE_VGA  = 2'd2,
      MODE_RSVD = 2'd3
   } video_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2,
      ST_PEND = 2'd3
   } ctrl_state_e;

   typedef struct packed {
      logic [11:0] ticks_per_line;
      logic [11:0] hs_pix_start;
      logic [11:0] hs_pix_stop;
      logic [11:0] vs_pix_start;
      logic [11:0] vs_pix_stop;
      logic [9:0]  lines_per_frame;
      logic [9:0]  vs_line_start;
      logic [9:0]  vs_line_stop;
      logic [9:0]  starting_line;
      logic        active_high_syncs;
   } mode_timing_t;

   // Counter terminal values are inclusive (count 0..N), hence the odd-looking totals.
   localparam mode_timing_t TIMING_NTSC = '{
      12'd1715, 12'd32, 12'd158, 12'd32, 12'd890,
      10'd524, 10'd6, 10'd12, 10'd4, 1'b0};
   localparam mode_timing_t TIMING_PAL = '{
      12'd1727, 12'd24, 12'd150, 12'd24, 12'd888,
      10'd624, 10'd0, 10'd5, 10'd0, 1'b0};
   localparam mode_timing_t TIMING_VGA = '{
      12'd799, 12'd656, 12'd752, 12'd0, 12'd0,
      10'd524, 10'd490, 10'd492, 10'd0, 1'b0};

endpackage

// File: rtl/video_mode_rom.sv
// Combinational mode-to-timing lookup; the reserved code falls back to NTSC.
module video_mode_rom
   import video_timer_pkg::*;
(
   input  logic [1:0]   mode_i,
   output mode_timing_t timing_o
);

   always_comb begin
      timing_o = TIMING_NTSC;
      case (mode_i)
         MODE_PAL: timing_o = TIMING_PAL;
         MODE_VGA: timing_o = TIMING_VGA;
         default:  timing_o = TIMING_NTSC;
      endcase
   end

endmodule

// File: rtl/video_timer_ctrl.sv
// Mode/settle controller for the video timer. Optional frame counter is enabled by
// defining VIDEO_TIMER_CTRL_FRAME_COUNT_EN.
module video_timer_ctrl
   import video_timer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        enable,
   input  logic        mode_req_valid,
   input  logic [1:0]  mode_req,
   output logic        mode_req_ready,
   input  logic [11:0] pix_counter,
   input  logic [9:0]  line_counter,
   output logic [11:0] ticks_per_line,
   output logic [11:0] hs_pix_start,
   output logic [11:0] hs_pix_stop,
   output logic [11:0] vs_pix_start,
   output logic [11:0] vs_pix_stop,
   output logic [9:0]  lines_per_frame,
   output logic [9:0]  vs_line_start,
   output logic [9:0]  vs_line_stop,
   output logic [9:0]  starting_line,
   output logic        active_high_syncs,
   output logic        reset_timer,
   output logic [1:0]  mode_active,
`ifdef VIDEO_TIMER_CTRL_FRAME_COUNT_EN
   output logic [15:0] frame_count,
`endif
   output logic        running,
   output logic        frame_start,
   output logic        mode_err
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   ctrl_state_e  state_q, state_d;
   video_mode_e  pend_q, pend_d;
   video_mode_e  mode_active_q;
   video_mode_e  load_mode;
   logic [3:0]   cnt_q, cnt_d;
   mode_timing_t cfg_q;
   mode_timing_t rom_timing;
   logic         ready_q, reset_timer_q, running_q, frame_start_q, mode_err_q;
   logic         accept, bad_req, good_req, eof, fs_hit, load;

   video_mode_rom u_rom (
      .mode_i   (load_mode),
      .timing_o (rom_timing)
   );

   always_comb begin
      accept   = mode_req_valid && ready_q;
      bad_req  = accept && (mode_req == MODE_RSVD);
      good_req = accept && (mode_req != MODE_RSVD);
      eof      = (pix_counter == cfg_q.ticks_per_line) &&
                 (line_counter == cfg_q.lines_per_frame);
      fs_hit   = ((state_q == ST_RUN) || (state_q == ST_PEND)) &&
                 (pix_counter == 12'd0) && (line_counter == 10'd0);

      state_d   = state_q;
      pend_d    = pend_q;
      cnt_d     = cnt_q;
      load      = 1'b0;
      load_mode = pend_q;

      case (state_q)
         ST_IDLE: begin
            if (good_req) begin
               load      = 1'b1;
               load_mode = video_mode_e'(mode_req);
            end
            if (enable) state_d = ST_HOLD;
            cnt_d = 4'd0;
         end
         ST_HOLD: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_RUN;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RUN: begin
            if (good_req) begin
               pend_d  = video_mode_e'(mode_req);
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            if (eof) begin
               load    = 1'b1;
               state_d = ST_HOLD;
               pend_d  = MODE_NTSC;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Parking overrides everything except an IDLE-time mode load.
      if (!enable) begin
         state_d = ST_IDLE;
         pend_d  = MODE_NTSC;
         cnt_d   = 4'd0;
         if (state_q != ST_IDLE) load = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q       <= ST_IDLE;
         pend_q        <= MODE_NTSC;
         cnt_q         <= 4'd0;
         mode_active_q <= MODE_NTSC;
         cfg_q         <= TIMING_NTSC;
         ready_q       <= 1'b1;
         reset_timer_q <= 1'b1;
         running_q     <= 1'b0;
         frame_start_q <= 1'b0;
         mode_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         cnt_q         <= cnt_d;
         ready_q       <= (state_d == ST_IDLE) || (state_d == ST_RUN);
         reset_timer_q <= (state_d == ST_IDLE) || (state_d == ST_HOLD);
         running_q     <= (state_d == ST_RUN) || (state_d == ST_PEND);
         frame_start_q <= fs_hit;
         mode_err_q    <= bad_req;
         if (load) begin
            cfg_q         <= rom_timing;
            mode_active_q <= load_mode;
         end
      end
   end

`ifdef VIDEO_TIMER_CTRL_FRAME_COUNT_EN
   logic [15:0] frame_count_q;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         frame_count_q <= 16'd0;
      end else if (load) begin
         frame_count_q <= 16'd0;
      end else if (fs_hit) begin
         frame_count_q <= frame_count_q + 16'd1;
      end
   end

   assign frame_count = frame_count_q;
`endif

   assign mode_req_ready    = ready_q;
   assign reset_timer       = reset_timer_q;
   assign running           = running_q;
   assign frame_start       = frame_start_q;
   assign mode_err          = mode_err_q;
   assign mode_active       = mode_active_q;
   assign ticks_per_line    = cfg_q.ticks_per_line;
   assign hs_pix_start      = cfg_q.hs_pix_start;
   assign hs_pix_stop       = cfg_q.hs_pix_stop;
   assign vs_pix_start      = cfg_q.vs_pix_start;
   assign vs_pix_stop       = cfg_q.vs_pix_stop;
   assign lines_per_frame   = cfg_q.lines_per_frame;
   assign vs_line_start     = cfg_q.vs_line_start;
   assign vs_line_stop      = cfg_q.vs_line_stop;
   assign starting_line     = cfg_q.starting_line;
   assign active_high_syncs = cfg_q.active_high_syncs;

endmodule

// File: tb/tb_video_timer_ctrl.sv
// Directed scoreboard bench for video_timer_ctrl; frame counter steps run when
// VIDEO_TIMER_CTRL_FRAME_COUNT_EN is defined.
module tb_video_timer_ctrl;

   logic        clk = 1'b0;
   logic        reset_b;
   logic        enable;
   logic        mode_req_valid;
   logic [1:0]  mode_req;
   logic        mode_req_ready;
   logic [11:0] pix_counter;
   logic [9:0]  line_counter;
   logic [11:0] ticks_per_line, hs_pix_start, hs_pix_stop, vs_pix_start, vs_pix_stop;
   logic [9:0]  lines_per_frame, vs_line_start, vs_line_stop, starting_line;
   logic        active_high_syncs;
   logic        reset_timer;
   logic [1:0]  mode_active;
   logic        running, frame_start, mode_err;
`ifdef VIDEO_TIMER_CTRL_FRAME_COUNT_EN
   logic [15:0] frame_count;
`endif

   video_timer_ctrl #(.SETTLE_CYCLES(4)) dut (
      .clk               (clk),
      .reset_b           (reset_b),
      .enable            (enable),
      .mode_req_valid    (mode_req_valid),
      .mode_req          (mode_req),
      .mode_req_ready    (mode_req_ready),
      .pix_counter       (pix_counter),
      .line_counter      (line_counter),
      .ticks_per_line    (ticks_per_line),
      .hs_pix_start      (hs_pix_start),
      .hs_pix_stop       (hs_pix_stop),
      .vs_pix_start      (vs_pix_start),
      .vs_pix_stop       (vs_pix_stop),
      .lines_per_frame   (lines_per_frame),
      .vs_line_start     (vs_line_start),
      .vs_line_stop      (vs_line_stop),
      .starting_line     (starting_line),
      .active_high_syncs (active_high_syncs),
      .reset_timer       (reset_timer),
      .mode_active       (mode_active),
`ifdef VIDEO_TIMER_CTRL_FRAME_COUNT_EN
      .frame_count       (frame_count),
`endif
      .running           (running),
      .frame_start       (frame_start),
      .mode_err          (mode_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   task automatic push(input string tag, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic pop(input logic [31:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         mismatched++;
         $error("FAIL sb_empty: observed %0d, expected nothing queued", obs);
      end else begin
         e = sb.pop_front();
         compared++;
         assert (obs === e.exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d, expected %0d", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_b        = 1'b1;
      enable         = 1'b0;
      mode_req_valid = 1'b0;
      mode_req       = 2'd0;
      pix_counter    = 12'd5;
      line_counter   = 10'd5;
      #1 reset_b = 1'b0;
      tick();

      // Reset state
      push("rst_reset_timer", 1); push("rst_tpl", 1715); push("rst_lpf", 524);
      push("rst_ready", 1); push("rst_running", 0); push("rst_mode_active", 0);
      pop(reset_timer); pop(ticks_per_line); pop(lines_per_frame);
      pop(mode_req_ready); pop(running); pop(mode_active);
      reset_b = 1'b1;
      tick();
      push("post_rst_ready", 1); push("post_rst_reset_timer", 1);
      pop(mode_req_ready); pop(reset_timer);

      // Start-up: 4 settle cycles then run
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         push("start_hold_reset_timer", 1); push("start_hold_ready", 0);
         pop(reset_timer); pop(mode_req_ready);
      end
      tick();
      push("start_run_reset_timer", 0); push("start_running", 1); push("start_ready", 1);
      pop(reset_timer); pop(running); pop(mode_req_ready);

      // Reserved mode request
      mode_req_valid = 1'b1; mode_req = 2'd3;
      tick();
      mode_req_valid = 1'b0;
      push("bad_mode_err", 1); push("bad_running", 1); push("bad_ready", 1);
      push("bad_mode_active", 0); push("bad_tpl", 1715);
      pop(mode_err); pop(running); pop(mode_req_ready); pop(mode_active); pop(ticks_per_line);
      tick();
      push("bad_mode_err_clear", 0);
      pop(mode_err);

      // Frame start pulse
      pix_counter = 12'd0; line_counter = 10'd0;
      tick();
      pix_counter = 12'd5; line_counter = 10'd5;
      push("fs_pulse", 1);
      pop(frame_start);
      tick();
      push("fs_clear", 0);
      pop(frame_start);

      // Mid-frame switch to PAL
      mode_req_valid = 1'b1; mode_req = 2'd1;
      tick();
      mode_req_valid = 1'b0;
      push("pend_ready", 0); push("pend_running", 1); push("pend_mode_active", 0);
      push("pend_tpl", 1715);
      pop(mode_req_ready); pop(running); pop(mode_active); pop(ticks_per_line);
      pix_counter = 12'd100;
      tick();
      push("pend_wait_tpl", 1715); push("pend_wait_ready", 0);
      pop(ticks_per_line); pop(mode_req_ready);
      pix_counter = 12'd1715; line_counter = 10'd524;
      tick();
      pix_counter = 12'd5; line_counter = 10'd5;
      push("load_tpl", 1727); push("load_lpf", 624); push("load_mode_active", 1);
      push("load_reset_timer", 1); push("load_running", 0);
      pop(ticks_per_line); pop(lines_per_frame); pop(mode_active);
      pop(reset_timer); pop(running);
      for (int i = 0; i < 3; i++) begin
         tick();
         push("load_hold_reset_timer", 1);
         pop(reset_timer);
      end
      tick();
      push("load_run_reset_timer", 0); push("load_running_again", 1);
      pop(reset_timer); pop(running);

      // Enable drop in PEND, coinciding with end of frame
      mode_req_valid = 1'b1; mode_req = 2'd2;
      tick();
      mode_req_valid = 1'b0;
      push("drop_pend_ready", 0);
      pop(mode_req_ready);
      enable = 1'b0; pix_counter = 12'd1727; line_counter = 10'd624;
      tick();
      pix_counter = 12'd5; line_counter = 10'd5;
      push("drop_reset_timer", 1); push("drop_running", 0); push("drop_ready", 1);
      push("drop_mode_active", 1); push("drop_tpl", 1727);
      pop(reset_timer); pop(running); pop(mode_req_ready); pop(mode_active); pop(ticks_per_line);

      // Load in IDLE while parked
      mode_req_valid = 1'b1; mode_req = 2'd2;
      tick();
      mode_req_valid = 1'b0;
      push("idle_load_mode_active", 2); push("idle_load_tpl", 799);
      push("idle_load_hs_start", 656); push("idle_load_reset_timer", 1); push("idle_load_running", 0);
      pop(mode_active); pop(ticks_per_line); pop(hs_pix_start); pop(reset_timer); pop(running);

`ifdef VIDEO_TIMER_CTRL_FRAME_COUNT_EN
      // Frame counter
      enable = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      push("fc_run", 1); push("fc_start", 0);
      pop(running); pop(frame_count);
      for (int i = 0; i < 3; i++) begin
         pix_counter = 12'd0; line_counter = 10'd0;
         tick();
         pix_counter = 12'd5; line_counter = 10'd5;
         tick();
      end
      push("fc_three", 3);
      pop(frame_count);
      mode_req_valid = 1'b1; mode_req = 2'd0;
      tick();
      mode_req_valid = 1'b0;
      pix_counter = 12'd799; line_counter = 10'd524;
      tick();
      pix_counter = 12'd5; line_counter = 10'd5;
      push("fc_load_clear", 0); push("fc_load_tpl", 1715);
      pop(frame_count); pop(ticks_per_line);
`endif

      if (sb.size() != 0) begin
         mismatched += sb.size();
         $error("FAIL sb_leftover: observed %0d unchecked entries, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
